// File: rtl/ad7656_sample_scheduler.sv
// Conversion sequencer for the four-ADC AD7656 wrapper: launches conversions,
// collects per-ADC done pulses, snapshots the sensor words and streams them out.
module ad7656_sample_scheduler #(
  parameter int ADC_NUM     = 4,
  parameter int SENSOR_NUM  = 20,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [31:0]             period_i,
  input  logic                    clear_i,
  input  logic [ADC_NUM-1:0]      convst_done_i,
  input  logic [SENSOR_NUM*16-1:0] wr_dout_i,
  output logic                    start_flag_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [15:0]             m_data_o,
  output logic [4:0]              m_chan_o,
  output logic                    m_last_o,
  output logic                    timeout_o,
  output logic [15:0]             overrun_cnt_o,
  output logic [31:0]             frame_cnt_o,
  output logic [1:0]              dbg_state_o
);

  // Stream: a word transfers on every clock where m_valid_o & m_ready_i; once
  // raised, m_valid_o and the payload hold until that transfer happens.
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, CAPT = 2'd2, SEND = 2'd3} state_t;

  localparam logic [4:0]  LAST_CHAN = 5'(SENSOR_NUM - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, period_q, period_eff;
  logic [31:0]        to_cnt_q;
  logic [ADC_NUM-1:0] mask_q;
  logic [15:0]        snap_q [SENSOR_NUM];
  logic               tick, all_done, to_hit, hs, last_hs, timeout_set, ovr_ev;
  logic [4:0]         chan_nxt;

  assign period_eff  = (period_i < 32'd2) ? 32'd2 : period_i;
  assign tick        = enable_i && (cnt_q == period_q - 32'd1);
  assign all_done    = &(mask_q | convst_done_i);
  assign to_hit      = (to_cnt_q == TO_LAST);
  assign hs          = m_valid_o & m_ready_i;
  assign last_hs     = hs && (m_chan_o == LAST_CHAN);
  assign timeout_set = (state_q == CONV) && !all_done && to_hit;
  assign ovr_ev      = tick && (state_q != IDLE);
  assign chan_nxt    = m_chan_o + 5'd1;
  assign dbg_state_o = state_q;

  // The period counter free-runs while enabled; busy states never stall it.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      period_q <= 32'd2;
    end else if (!enable_i) begin
      cnt_q    <= '0;
      period_q <= period_eff;
    end else if (tick) begin
      cnt_q    <= '0;
      period_q <= period_eff;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (tick) state_d = CONV;
      CONV: begin
        if (all_done)    state_d = CAPT;
        else if (to_hit) state_d = IDLE;
      end
      CAPT: state_d = SEND;
      SEND: if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_flag_o  <= 1'b0;
      mask_q        <= '0;
      to_cnt_q      <= '0;
      m_valid_o     <= 1'b0;
      m_data_o      <= '0;
      m_chan_o      <= '0;
      m_last_o      <= 1'b0;
      timeout_o     <= 1'b0;
      overrun_cnt_o <= '0;
      frame_cnt_o   <= '0;
      for (int k = 0; k < SENSOR_NUM; k++) snap_q[k] <= '0;
    end else begin
      start_flag_o <= (state_q == IDLE) && tick;

      // A new event in the same cycle as clear_i takes precedence.
      if (timeout_set)  timeout_o <= 1'b1;
      else if (clear_i) timeout_o <= 1'b0;

      if (ovr_ev) begin
        if (clear_i)                        overrun_cnt_o <= 16'd1;
        else if (overrun_cnt_o != 16'hFFFF) overrun_cnt_o <= overrun_cnt_o + 16'd1;
      end else if (clear_i) begin
        overrun_cnt_o <= '0;
      end

      case (state_q)
        IDLE: begin
          mask_q   <= '0;
          to_cnt_q <= '0;
        end
        CONV: begin
          mask_q   <= mask_q | convst_done_i;
          to_cnt_q <= to_cnt_q + 32'd1;
        end
        CAPT: begin
          for (int k = 0; k < SENSOR_NUM; k++) snap_q[k] <= wr_dout_i[k*16 +: 16];
          m_valid_o <= 1'b1;
          m_data_o  <= wr_dout_i[15:0];
          m_chan_o  <= '0;
          m_last_o  <= (SENSOR_NUM == 1);
        end
        SEND: begin
          if (last_hs) begin
            m_valid_o   <= 1'b0;
            m_data_o    <= '0;
            m_chan_o    <= '0;
            m_last_o    <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 32'd1;
          end else if (hs) begin
            m_chan_o <= chan_nxt;
            m_data_o <= snap_q[chan_nxt];
            m_last_o <= (chan_nxt == LAST_CHAN);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7656_sample_scheduler.sv
// Directed bench for ad7656_sample_scheduler: two instances, one with the
// default timeout and one with a 100-cycle timeout, driven by shared inputs.
module tb_ad7656_sample_scheduler;

  logic         clk = 1'b0;
  logic         rst_n, enable, clear, ready;
  logic [31:0]  period;
  logic [3:0]   done;
  logic [319:0] wr_dout;

  logic        start, valid, last, timeout;
  logic [15:0] data, ovr;
  logic [4:0]  chan;
  logic [31:0] frame;
  logic [1:0]  state;

  logic        t_start, t_valid, t_last, t_timeout;
  logic [15:0] t_data, t_ovr;
  logic [4:0]  t_chan;
  logic [31:0] t_frame;
  logic [1:0]  t_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  ad7656_sample_scheduler dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .period_i(period),
    .clear_i(clear), .convst_done_i(done), .wr_dout_i(wr_dout),
    .start_flag_o(start), .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data),
    .m_chan_o(chan), .m_last_o(last), .timeout_o(timeout), .overrun_cnt_o(ovr),
    .frame_cnt_o(frame), .dbg_state_o(state)
  );

  ad7656_sample_scheduler #(.TIMEOUT_CYC(100)) dut_to (
    .sys_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .period_i(period),
    .clear_i(clear), .convst_done_i(done), .wr_dout_i(wr_dout),
    .start_flag_o(t_start), .m_valid_o(t_valid), .m_ready_i(ready), .m_data_o(t_data),
    .m_chan_o(t_chan), .m_last_o(t_last), .timeout_o(t_timeout), .overrun_cnt_o(t_ovr),
    .frame_cnt_o(t_frame), .dbg_state_o(t_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; done = 4'h0; ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_start(input bit on_to, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (on_to ? t_start : start) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Twenty words with ready held high, starting from word 0 on the current cycle.
  task automatic check_stream(input string tag);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(valid), 1);
      check($sformatf("%s_data%0d", tag, i), 32'(data), 32'h1000 + i);
      check($sformatf("%s_chan%0d", tag, i), 32'(chan), i);
      check($sformatf("%s_last%0d", tag, i), 32'(last), (i == 19) ? 1 : 0);
      step();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_data"},  32'(data), 0);
    check({tag, "_chan"},  32'(chan), 0);
    check({tag, "_last"},  32'(last), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_ovr"},   32'(ovr), 0);
    check({tag, "_frame"}, frame, 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    int hs_cnt, idx, to_at;
    bit found;
    for (int k = 0; k < 20; k++) wr_dout[k*16 +: 16] = 16'h1000 + 16'(k);
    period = 32'd1000;

    // Reset values on both instances
    do_reset();
    check_zero_outputs("rst");
    check("rst_t_start", 32'(t_start), 0);
    check("rst_t_valid", 32'(t_valid), 0);
    check("rst_t_data", 32'(t_data), 0);
    check("rst_t_chan", 32'(t_chan), 0);
    check("rst_t_last", 32'(t_last), 0);
    check("rst_t_timeout", 32'(t_timeout), 0);
    check("rst_t_ovr", 32'(t_ovr), 0);
    check("rst_t_frame", t_frame, 0);
    check("rst_t_state", 32'(t_state), 0);

    // Basic frame, period 1000, done 200 cycles after start
    period = 32'd1000; step();
    enable = 1'b1;
    wait_start(0, 1100, n);
    check("t1_first_start", n, 1000);
    step();
    check("t1_start_one_cycle", 32'(start), 0);
    repeat (199) step();
    check("t1_conv_state", 32'(state), 1);
    done = 4'hF; step(); done = 4'h0;
    check("t1_capt_no_valid", 32'(valid), 0);
    step();
    check_stream("t1");
    check("t1_valid_drop", 32'(valid), 0);
    check("t1_frame", frame, 1);
    wait_start(0, 1000, n);
    check("t1_second_start", n, 778);

    // Staggered and simultaneous done pulses
    do_reset();
    period = 32'd1000; step();
    enable = 1'b1;
    wait_start(0, 1100, n);
    check("t2_first_start", n, 1000);
    repeat (10) step();
    done = 4'b0011; step(); done = 4'h0;
    repeat (4) step();
    done = 4'b0100; step(); done = 4'h0;
    repeat (4) step();
    check("t2_no_valid_before_adc3", 32'(valid), 0);
    check("t2_still_conv", 32'(state), 1);
    done = 4'b1000; step(); done = 4'h0;
    check("t2_valid_plus1", 32'(valid), 0);
    step();
    check_stream("t2");
    check("t2_frame", frame, 1);

    // Backpressure: ready alternates 0/1 every cycle
    do_reset();
    period = 32'd1000; step();
    enable = 1'b1;
    wait_start(0, 1100, n);
    done = 4'hF; step(); done = 4'h0;
    step();
    idx = 0; hs_cnt = 0;
    for (int c = 0; c < 100 && hs_cnt < 20; c++) begin
      ready = c[0];
      check($sformatf("t3_valid_c%0d", c), 32'(valid), 1);
      check($sformatf("t3_chan_c%0d", c), 32'(chan), idx);
      check($sformatf("t3_data_c%0d", c), 32'(data), 32'h1000 + idx);
      check($sformatf("t3_last_c%0d", c), 32'(last), (idx == 19) ? 1 : 0);
      if (ready) begin
        idx++;
        hs_cnt++;
      end
      step();
    end
    ready = 1'b1;
    check("t3_handshakes", hs_cnt, 20);
    check("t3_valid_drop", 32'(valid), 0);
    check("t3_frame", frame, 1);

    // Timeout on the 100-cycle instance, ADC2 never completes
    do_reset();
    period = 32'd1000; step();
    enable = 1'b1;
    wait_start(1, 1100, n);
    check("t4_first_start", n, 1000);
    saw_valid = 1'b0; to_at = -1;
    for (int i = 1; i <= 150; i++) begin
      done = 4'b1011;
      step();
      if (t_valid) saw_valid = 1'b1;
      if (t_timeout) begin
        to_at = i;
        break;
      end
    end
    done = 4'h0;
    check("t4_timeout_delay", to_at, 100);
    check("t4_no_valid", 32'(saw_valid), 0);
    check("t4_back_idle", 32'(t_state), 0);
    check("t4_frame", t_frame, 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("t4_clear", 32'(t_timeout), 0);
    wait_start(1, 1000, n);
    check("t4_next_start", n, 899);
    repeat (99) step();
    check("t4_not_yet", 32'(t_timeout), 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("t4_set_beats_clear", 32'(t_timeout), 1);
    check("t4_no_overrun", 32'(t_ovr), 0);

    // Overrun: period 10, sink stalled for 50 cycles
    do_reset();
    period = 32'd10; step();
    enable = 1'b1;
    wait_start(0, 20, n);
    check("t5_first_start", n, 10);
    done = 4'hF; ready = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 1) done = 4'h0;
      if (i == 9) check("t5_ovr_s9", 32'(ovr), 0);
      if (i == 10) check("t5_ovr_s10", 32'(ovr), 1);
      if (i == 20) check("t5_ovr_s20", 32'(ovr), 2);
    end
    check("t5_ovr_s50", 32'(ovr), 5);
    ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      check($sformatf("t5_data%0d", j), 32'(data), 32'h1000 + j);
      check($sformatf("t5_chan%0d", j), 32'(chan), j);
      check($sformatf("t5_last%0d", j), 32'(last), (j == 19) ? 1 : 0);
      clear = (j == 9);
      step();
      clear = 1'b0;
      if (j == 9) check("t5_clear_and_tick", 32'(ovr), 1);
    end
    check("t5_valid_drop", 32'(valid), 0);
    check("t5_ovr_final", 32'(ovr), 2);
    check("t5_frame", frame, 1);
    repeat (9) step();
    check("t5_no_early_start", 32'(start), 0);
    step();
    check("t5_restart", 32'(start), 1);

    // Reset in the middle of SEND, then period 0 behaves as 2
    do_reset();
    period = 32'd10; step();
    enable = 1'b1;
    wait_start(0, 20, n);
    done = 4'hF; step(); done = 4'h0;
    step();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid && chan == 5'd7) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t6_reach_chan7", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6_async");
    period = 32'd0; enable = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    enable = 1'b1;
    wait_start(0, 10, n);
    check("t6_p0_first_start", n, 2);
    step();
    check("t6_ovr_s1", 32'(ovr), 0);
    step();
    check("t6_ovr_s2", 32'(ovr), 1);
    repeat (2) step();
    check("t6_ovr_s4", 32'(ovr), 2);
    repeat (2) step();
    check("t6_ovr_s6", 32'(ovr), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
